rectangle_key_unroll: RTL and testbench

Sequential RECTANGLE-80 decryption key schedule. Takes the 80-bit master key, runs the forward key update 25 times to reach the final key state, then walks the schedule backwards, emitting round keys K25 down to K0 one per handshake. It feeds the decryption datapath, which consumes round keys in reverse order. It is the inverse counterpart of the existing combinational forward key-update logic.

---
 rtl/rectangle_pkg.sv | 33 +++
 rtl/rectangle_inv_sbox.sv | 28 ++
 rtl/sbox.sv | 28 ++
 rtl/rectangle_key_unroll.sv | 141 ++++++++++++++
 tb/tb_rectangle_key_unroll.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rectangle_pkg.sv
// Shared constants, FSM encoding and bit-manipulation helpers for the
// RECTANGLE-80 key schedule.
package rectangle_pkg;

   localparam int         NUM_ROUNDS = 25;
   localparam logic [4:0] RC_INIT    = 5'h01;
   localparam logic [4:0] RC_LAST    = 5'h1D;
   localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
   localparam logic [4:0] FIRST_IDX  = 5'(NUM_ROUNDS);

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      EMIT
   } state_t;

   function automatic logic [15:0] rol8(input logic [15:0] x);
      return {x[7:0], x[15:8]};
   endfunction

   function automatic logic [15:0] rol12(input logic [15:0] x);
      return {x[3:0], x[15:4]};
   endfunction

   function automatic logic [4:0] rc_next(input logic [4:0] rc);
      return {rc[3:0], rc[4] ^ rc[2]};
   endfunction

   function automatic logic [4:0] rc_prev(input logic [4:0] rc);
      return {rc[0] ^ rc[3], rc[4:1]};
   endfunction

endpackage

// File: rtl/rectangle_inv_sbox.sv
// RECTANGLE 4-bit inverse S-box, purely combinational.
module rectangle_inv_sbox (
   input  logic [3:0] a,
   output logic [3:0] y
);

   always_comb begin
      case (a)
         4'h0: y = 4'h9;
         4'h1: y = 4'h4;
         4'h2: y = 4'hF;
         4'h3: y = 4'hA;
         4'h4: y = 4'hE;
         4'h5: y = 4'h1;
         4'h6: y = 4'h0;
         4'h7: y = 4'h6;
         4'h8: y = 4'hC;
         4'h9: y = 4'h7;
         4'hA: y = 4'h3;
         4'hB: y = 4'h8;
         4'hC: y = 4'h2;
         4'hD: y = 4'hB;
         4'hE: y = 4'h5;
         default: y = 4'hD;
      endcase
   end

endmodule

// File: rtl/sbox.sv
// RECTANGLE 4-bit forward S-box, purely combinational.
module sbox (
   input  logic [3:0] a,
   output logic [3:0] y
);

   always_comb begin
      case (a)
         4'h0: y = 4'h6;
         4'h1: y = 4'h5;
         4'h2: y = 4'hC;
         4'h3: y = 4'hA;
         4'h4: y = 4'h1;
         4'h5: y = 4'hE;
         4'h6: y = 4'h7;
         4'h7: y = 4'h9;
         4'h8: y = 4'hB;
         4'h9: y = 4'h0;
         4'hA: y = 4'h3;
         4'hB: y = 4'hD;
         4'hC: y = 4'h8;
         4'hD: y = 4'hF;
         4'hE: y = 4'h4;
         default: y = 4'h2;
      endcase
   end

endmodule

// File: rtl/rectangle_key_unroll.sv
// RECTANGLE-80 decryption key schedule: expands the master key forward 25
// rounds, then emits round keys K25..K0 by running the key update backwards.
module rectangle_key_unroll
   import rectangle_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [79:0] key_in,
   output logic        busy,
   output logic        rk_valid,
   input  logic        rk_ready,
   output logic [63:0] rk_out,
   output logic [4:0]  rk_idx,
   output logic        done
);

   state_t      state, state_nx;
   logic [79:0] s, s_nx;
   logic [4:0]  rc, rc_nx;
   logic [4:0]  cnt, cnt_nx;
   logic        done_nx;

   logic [15:0] r0, r1, r2, r3, r4;
   assign {r4, r3, r2, r1, r0} = s;

   // Inverse round: undo constant and row mixing before the inverse S-box.
   logic [15:0] ia0, ia1, ia2, ia3, ia4;
   assign ia0 = r4;
   assign ia1 = r0 ^ {11'd0, rc} ^ rol8(ia0);
   assign ia2 = r1;
   assign ia3 = r2;
   assign ia4 = r3 ^ rol12(ia3);

   logic [3:0] fcol [4];
   logic [3:0] icol [4];

   for (genvar c = 0; c < 4; c++) begin : g_col
      sbox u_sbox (
         .a ({r3[c], r2[c], r1[c], r0[c]}),
         .y (fcol[c])
      );
      rectangle_inv_sbox u_inv_sbox (
         .a ({ia3[c], ia2[c], ia1[c], ia0[c]}),
         .y (icol[c])
      );
   end

   logic [15:0] fa0, fa1, fa2, fa3;
   logic [15:0] ib0, ib1, ib2, ib3;
   logic [79:0] s_fwd, s_inv;

   always_comb begin
      // NOTE: every combinational output gets a default before any branch so no latch is inferred.
      fa0 = r0;
      fa1 = r1;
      fa2 = r2;
      fa3 = r3;
      ib0 = ia0;
      ib1 = ia1;
      ib2 = ia2;
      ib3 = ia3;
      for (int c = 0; c < 4; c++) begin
         fa0[c] = fcol[c][0];
         fa1[c] = fcol[c][1];
         fa2[c] = fcol[c][2];
         fa3[c] = fcol[c][3];
         ib0[c] = icol[c][0];
         ib1[c] = icol[c][1];
         ib2[c] = icol[c][2];
         ib3[c] = icol[c][3];
      end
      s_fwd = {fa0, rol12(fa3) ^ r4, fa3, fa2, rol8(fa0) ^ fa1 ^ {11'd0, rc}};
      s_inv = {ia4, ib3, ib2, ib1, ib0};
   end

   always_comb begin
      state_nx = state;
      s_nx     = s;
      rc_nx    = rc;
      cnt_nx   = cnt;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               s_nx     = key_in;
               rc_nx    = RC_INIT;
               cnt_nx   = 5'd0;
               state_nx = EXPAND;
            end
         end
         EXPAND: begin
            s_nx = s_fwd;
            if (cnt == LAST_ROUND) begin
               rc_nx    = RC_LAST;
               cnt_nx   = FIRST_IDX;
               state_nx = EMIT;
            end else begin
               rc_nx  = rc_next(rc);
               cnt_nx = cnt + 5'd1;
            end
         end
         EMIT: begin
            if (rk_ready) begin
               if (cnt != 5'd0) begin
                  s_nx   = s_inv;
                  rc_nx  = rc_prev(rc);
                  cnt_nx = cnt - 5'd1;
               end else begin
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         s     <= '0;
         rc    <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         s     <= s_nx;
         rc    <= rc_nx;
         cnt   <= cnt_nx;
         done  <= done_nx;
      end
   end

   assign busy     = (state != IDLE);
   assign rk_valid = (state == EMIT);
   assign rk_out   = s[63:0];
   assign rk_idx   = rk_valid ? cnt : 5'd0;

endmodule

// File: tb/tb_rectangle_key_unroll.sv
// Scoreboard bench: a forward key-schedule model fills the expected queue in
// reverse order; a monitor pops and compares every accepted beat.
module tb_rectangle_key_unroll;

   localparam int SBOX [16] = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};

   typedef struct packed {
      logic [4:0]  idx;
      logic [63:0] rk;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [79:0] key_in = '0;
   logic        busy;
   logic        rk_valid;
   logic        rk_ready = 1'b1;
   logic [63:0] rk_out;
   logic [4:0]  rk_idx;
   logic        done;

   int    n_vec = 0;
   int    n_bad = 0;
   int    cyc = 0;
   bit    ready_rand = 1'b0;
   beat_t exp_q [$];

   int          first_valid_edge = -1;
   int          done_edge = -1;
   logic        busy_at_done = 1'b0;
   logic [63:0] last_out = '0;
   logic [4:0]  last_idx = '0;

   rectangle_key_unroll dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key_in   (key_in),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_out   (rk_out),
      .rk_idx   (rk_idx),
      .done     (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rol(input int x, input int n);
      return ((x << n) | (x >> (16 - n))) & 'hFFFF;
   endfunction

   function automatic logic [79:0] model_round(input logic [79:0] s, input int rc);
      int r [5];
      int n [5];
      int nib, sb;
      for (int k = 0; k < 5; k++) r[k] = int'(s[16*k +: 16]);
      for (int c = 0; c < 4; c++) begin
         nib = 0;
         for (int k = 0; k < 4; k++) nib = nib | (((r[k] >> c) & 1) << k);
         sb = SBOX[nib];
         for (int k = 0; k < 4; k++) r[k] = (r[k] & ~(1 << c)) | (((sb >> k) & 1) << c);
      end
      n[0] = rol(r[0], 8) ^ r[1] ^ rc;
      n[1] = r[2];
      n[2] = r[3];
      n[3] = rol(r[3], 12) ^ r[4];
      n[4] = r[0];
      return {16'(n[4]), 16'(n[3]), 16'(n[2]), 16'(n[1]), 16'(n[0])};
   endfunction

   function automatic void push_expected(input logic [79:0] key);
      logic [79:0] k [26];
      int rc = 1;
      k[0] = key;
      for (int i = 0; i < 25; i++) begin
         k[i+1] = model_round(k[i], rc);
         rc = ((rc << 1) & 31) | (((rc >> 4) ^ (rc >> 2)) & 1);
      end
      for (int i = 25; i >= 0; i--) exp_q.push_back('{idx: 5'(i), rk: k[i][63:0]});
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rk_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: scoreboard pops, stall stability, first-beat and done timing.
   initial begin
      bit          stalled = 1'b0;
      logic [63:0] hold_out = '0;
      logic [4:0]  hold_idx = '0;
      beat_t       e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
         end else begin
            if (stalled && rk_valid) begin
               check("stall_rk_out", rk_out, hold_out);
               check("stall_rk_idx", rk_idx, hold_idx);
            end
            if (rk_valid && first_valid_edge < 0) first_valid_edge = cyc;
            if (done && done_edge < 0) begin
               done_edge    = cyc;
               busy_at_done = busy;
            end
            if (rk_valid && rk_ready) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL unexpected_beat: got idx %0d rk %h expected no beat", rk_idx, rk_out);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_idx", rk_idx, e.idx);
                  check("beat_rk", rk_out, e.rk);
               end
               last_out = rk_out;
               last_idx = rk_idx;
            end
            stalled  = rk_valid && !rk_ready;
            hold_out = rk_out;
            hold_idx = rk_idx;
         end
      end
   end

   task automatic run(input logic [79:0] key, input bit rnd, input bit inject);
      int t_edge;
      int waited;
      ready_rand = rnd;
      push_expected(key);
      @(posedge clk);
      #1;
      first_valid_edge = -1;
      done_edge        = -1;
      start  = 1'b1;
      key_in = key;
      t_edge = cyc + 1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      key_in = {$urandom, $urandom, 16'($urandom)};
      if (inject) begin
         repeat (4) @(posedge clk);
         #1;
         start  = 1'b1;
         key_in = ~key;
         @(posedge clk);
         #1;
         start = 1'b0;
         repeat (24) @(posedge clk);
         #1;
         start  = 1'b1;
         key_in = ~key;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      waited = 0;
      while (done_edge < 0 && waited < 2000) begin
         @(posedge clk);
         waited++;
      end
      check("done_seen", 80'(done_edge >= 0), 80'd1);
      check("busy_at_done", busy_at_done, 1'b0);
      check("queue_drained", exp_q.size(), 0);
      check("last_rk_out", last_out, key[63:0]);
      check("last_rk_idx", last_idx, 5'd0);
      if (!rnd) begin
         check("first_valid_edge", first_valid_edge, t_edge + 25);
         check("done_edge", done_edge, t_edge + 51);
      end
      exp_q.delete();
   endtask

   task automatic reset_mid_emit(input logic [79:0] key);
      int waited;
      ready_rand = 1'b0;
      push_expected(key);
      @(posedge clk);
      #1;
      start  = 1'b1;
      key_in = key;
      @(posedge clk);
      #1;
      start = 1'b0;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!(rk_valid && rk_idx == 5'd12) && waited < 200);
      check("reach_idx12", rk_idx, 5'd12);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_rk_valid", rk_valid, 1'b0);
      check("rst_rk_out", rk_out, 64'd0);
      check("rst_rk_idx", rk_idx, 5'd0);
      check("rst_done", done, 1'b0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("post_rst_idle", {busy, rk_valid}, 2'b00);
      end
   endtask

   initial begin
      logic [79:0] k;
      #3;
      check("reset_busy", busy, 1'b0);
      check("reset_rk_valid", rk_valid, 1'b0);
      check("reset_rk_out", rk_out, 64'd0);
      check("reset_rk_idx", rk_idx, 5'd0);
      check("reset_done", done, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_busy", busy, 1'b0);
         check("idle_rk_valid", rk_valid, 1'b0);
      end

      run(80'h0123_4567_89AB_CDEF_FEDC, 1'b0, 1'b0);
      run('0, 1'b0, 1'b0);
      run('1, 1'b0, 1'b0);
      run(80'h0123_4567_89AB_CDEF_FEDC, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         k = {$urandom, $urandom, 16'($urandom)};
         run(k, 1'b1, 1'b0);
      end
      k = {$urandom, $urandom, 16'($urandom)};
      run(k, 1'b0, 1'b1);
      reset_mid_emit(80'h0123_4567_89AB_CDEF_FEDC);
      k = {$urandom, $urandom, 16'($urandom)};
      run(k, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
